// File: rtl/bch_enc_127x141.sv
// bch_enc_127x141 -- systematic BCH(127,113)-style encoder, 127 data bits + 14 parity.
// Generator g(x) = x^14 + x^9 + x^8 + x^6 + x^5 + x^4 + x^2 + x + 1 (0x4377).
// Optional macro ENC_TOP_OUT_REG_EN adds a 141-bit output register with
// synchronous active-high reset and 1-cycle latency. Without it the block is
// purely combinational, and clk/rst are kept only so both builds share one port list.
module bch_enc_127x141 (
    input  logic         clk,
    input  logic         rst,
    input  logic [126:0] IN,
    output logic [140:0] OUT
);

    // g(x) with the x^14 term dropped; this is the feedback tap mask of the divider.
    localparam logic [13:0] GEN_LOW = 14'h0377;

    logic [13:0]  w_parity;
    logic [140:0] w_code;

    // Unrolled LFSR division of IN(x)*x^14 by g(x), MSB first.
    // After unrolling, each parity bit is a fixed XOR of IN bits.
    always_comb begin
        logic [13:0] v_rem;
        logic        v_fb;
        v_rem = '0;
        v_fb  = 1'b0;
        for (int i = 126; i >= 0; i--) begin
            v_fb  = IN[i] ^ v_rem[13];
            v_rem = {v_rem[12:0], 1'b0};
            if (v_fb) begin
                v_rem = v_rem ^ GEN_LOW;
            end
        end
        w_parity = v_rem;
    end

    assign w_code = {IN, w_parity};

`ifdef ENC_TOP_OUT_REG_EN
    logic [140:0] r_out;

    // Output register; clearing to zero still leaves a valid codeword.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out <= '0;
        end else begin
            r_out <= w_code;
        end
    end

    assign OUT = r_out;
`else
    // In the combinational build clk and rst go nowhere. They are folded into this net so lint does not flag them.
    logic w_unused_clk_rst;
    assign w_unused_clk_rst = clk ^ rst;

    assign OUT = w_code;
`endif

endmodule

// File: tb/tb_bch_enc_127x141.sv
// tb_bch_enc_127x141 -- directed table, random sweep and reset/stream sequences.
// Works for both builds: define ENC_TOP_OUT_REG_EN to test the registered variant.
module tb_bch_enc_127x141;

    localparam logic [14:0] GEN = 15'h4377;

    logic         clk;
    logic         rst;
    logic [126:0] IN;
    logic [140:0] OUT;

    int n_vec;
    int n_err;

    bch_enc_127x141 dut (
        .clk (clk),
        .rst (rst),
        .IN  (IN),
        .OUT (OUT)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [126:0] in;
        logic [140:0] exp;
    } vec_t;

    // Remainder of a 141-bit polynomial divided by g(x), using schoolbook long division.
    function automatic logic [13:0] poly_rem(input logic [140:0] c);
        logic [140:0] t;
        t = c;
        for (int i = 140; i >= 14; i--) begin
            if (t[i]) t[i -: 15] = t[i -: 15] ^ GEN;
        end
        return t[13:0];
    endfunction

    function automatic logic [140:0] ref_enc(input logic [126:0] d);
        return {d, poly_rem({d, 14'b0})};
    endfunction

    function automatic logic [126:0] rand127();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return r[126:0];
    endfunction

    task automatic check(input string name, input logic [140:0] act, input logic [140:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Apply one word between edges and sample it just after the next rising edge.
    task automatic apply(input logic [126:0] d);
        @(negedge clk);
        IN = d;
        @(posedge clk);
        #1;
    endtask

    vec_t         tbl[8];
    logic [126:0] a, b, sa[$];
    logic [140:0] oa, ob;

    initial begin
        logic [126:0] one;
        one = 127'd1;
        tbl[0] = '{127'd0,       141'd0};
        tbl[1] = '{one,          {one, 14'h0377}};
        tbl[2] = '{one << 113,   {one << 113, 14'h0001}};
        tbl[3] = '{one << 126,   {one << 126, 14'h2000}};
        tbl[4] = '{one << 1,     {one << 1, 14'h06EE}};
        tbl[5] = '{127'd3,       {127'd3, 14'h0599}};
        tbl[6] = '{one << 4,     {one << 4, 14'h3770}};
        tbl[7] = '{one << 5,     {one << 5, 14'h2D97}};

        n_vec = 0;
        n_err = 0;
        rst   = 1'b0;
        IN    = '0;

        // Hold rst for two edges with IN = 1; the registered build must read zero each time.
        @(negedge clk);
        rst = 1'b1;
        IN  = 127'd1;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
`ifdef ENC_TOP_OUT_REG_EN
            check("reset_hold", OUT, 141'd0);
`else
            check("reset_hold", OUT, {127'd1, 14'h0377});
`endif
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("reset_release", OUT, {127'd1, 14'h0377});

        foreach (tbl[k]) begin
            apply(tbl[k].in);
            check($sformatf("table_%0d", k), OUT, tbl[k].exp);
        end

        // Random sweep, starting with the two fixed words: data passes through unchanged and OUT(x) is a multiple of g(x).
        for (int k = 0; k < 1000; k++) begin
            if (k == 0)      a = 127'd111280905621495480921325258608442123583;
            else if (k == 1) a = 127'd2350736407967074960062813466992612915;
            else             a = rand127();
            apply(a);
            check("sweep_data", {OUT[140:14], 14'b0}, {a, 14'b0});
            check("sweep_rem0", {127'b0, poly_rem(OUT)}, 141'd0);
            if (k % 10 == 0) check("sweep_model", OUT, ref_enc(a));
        end

        // Linearity: OUT(a^b) == OUT(a) ^ OUT(b)
        for (int k = 0; k < 40; k++) begin
            a = rand127();
            b = rand127();
            apply(a);
            oa = OUT;
            apply(b);
            ob = OUT;
            apply(a ^ b);
            check("linearity", OUT, oa ^ ob);
        end

        // Back-to-back stream: a new word each cycle, each checked on the edge after it is applied.
        for (int k = 0; k < 64; k++) sa.push_back(rand127());
        foreach (sa[k]) begin
            apply(sa[k]);
            check("stream", OUT, ref_enc(sa[k]));
        end

        // Assert rst in the middle of the stream. The in-flight word is dropped, and the edge after rst clears loads the current IN.
        a = rand127();
        b = rand127();
        @(negedge clk);
        IN  = a;
        rst = 1'b1;
        @(posedge clk);
        #1;
`ifdef ENC_TOP_OUT_REG_EN
        check("midstream_rst", OUT, 141'd0);
`else
        check("midstream_rst", OUT, ref_enc(a));
`endif
        @(negedge clk);
        rst = 1'b0;
        IN  = b;
        @(posedge clk);
        #1;
        check("post_rst_load", OUT, ref_enc(b));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bch_enc_127x141.md
# bch_enc_127x141

Systematic binary BCH-style encoder for a 127-bit data word. It appends 14 parity bits, computed with the degree-14 generator of the double-error-correcting BCH(127,113) code, to form a 141-bit codeword. It sits on the write path ahead of storage/transport, and its output feeds the matching BCH decoder.

## Interface

Parameters:
- none; all widths are fixed.

Ports:
- `clk` input 1 — single clock. The block is synchronous and active-high reset, on the rising edge of `clk`.
- `rst` input 1 — synchronous reset, active-high.
- `IN` input 127 — message word. `IN[126]` is the coefficient of x^126; `IN[0]` is the coefficient of x^0.
- `OUT` output 141 — codeword. `OUT[140:14]` = `IN`; `OUT[13:0]` = parity.

## Operation

- The generator polynomial is g(x) = x^14 + x^9 + x^8 + x^6 + x^5 + x^4 + x^2 + x + 1.
  - Its hex form is 0x4377, and its octal form is 41567.
  - g(x) = m1(x)·m3(x) over GF(2^7), and g(x) divides x^127 + 1.
- Parity polynomial: p(x) = (IN(x)·x^14) mod g(x), computed over GF(2).
  - `OUT[13]` is the coefficient of x^13; `OUT[0]` is the coefficient of x^0.
- The codeword polynomial C(x) = IN(x)·x^14 + p(x) is divisible by g(x).
- Implementation: a fully parallel XOR network.
  - Each parity bit is the XOR of a fixed subset of `IN` bits.
  - The subsets are derived at elaboration from the remainders x^(i+14) mod g(x), for i = 0..126.
  - An unrolled LFSR division loop is acceptable.
- No state, no handshake, and no valid signal: every clock (or every input change, see Configuration) yields a new codeword.
- The encoding is linear: OUT(a ^ b) = OUT(a) ^ OUT(b).
- Boundary conditions:
  - All-zero input gives an all-zero codeword.
  - No input value is illegal.
  - X/Z on `IN` is not handled specially.

## Timing

- Default build: `OUT` is purely combinational from `IN`.
  - Zero latency; `clk` and `rst` have no effect.
  - `OUT` reflects the current `IN` after propagation delay.
- With `ENC_TOP_OUT_REG_EN`: `OUT` is registered.
  - Latency is 1 cycle: `OUT` at edge n+1 is the encoding of `IN` sampled at edge n.
  - Throughput is one word per cycle.
- Reset, registered build only:
  - When `rst` is high at a rising edge, `OUT` becomes 141'b0 at that edge, which is a valid codeword.
  - `OUT` holds 0 for every edge at which `rst` stays high.
  - On the first edge after `rst` deasserts, `OUT` loads the encoding of the current `IN`.
  - Reset asserted mid-stream discards the in-flight word.

## Configuration

- Macro: `ENC_TOP_OUT_REG_EN`.
- Defined: a 141-bit output register is inserted after the XOR network, with synchronous active-high reset to zero and 1-cycle latency.
- Undefined: the block is combinational; `clk` and `rst` are present but unused, and the port list is identical in both builds.

## Test plan

In each scenario below, a registered build checks one cycle after `IN` is applied.
- `IN` = 0 -> `OUT` = 0. Registered build: assert `rst` for 2 cycles with `IN` = 1 -> `OUT` = 0 throughout reset.
- `IN` = 127'h1 -> `OUT` = 141'h4377, i.e. parity 0x0377 (equal to g(x) − x^14).
- `IN` = 1<<113 -> `OUT` = (1<<127) | 14'h0001. This holds because x^127 ≡ 1 mod g(x).
- `IN` = 1<<126 -> `OUT` = (1<<140) | 14'h2000. This holds because x^140 ≡ x^13 mod g(x).
- Random sweep of at least 1000 words, including 111280905621495480921325258608442123583 and 2350736407967074960062813466992612915:
  - `OUT[140:14]` == `IN`.
  - A reference LFSR divide of `OUT` by 0x4377 gives remainder 0.
  - Linearity holds for random pairs.
- Registered build, back-to-back stream: a new `IN` every cycle -> each `OUT` matches its input delayed by exactly 1 cycle, with no bubbles.
